// File: rtl/button_debouncer.sv
// button_debouncer
//   Multi-channel push-button conditioner. Each raw pin is brought into the
//   clk domain through a two-flop synchroniser. A per-channel FSM with a
//   settle counter then accepts a new level only after it has been stable for
//   CNT_MAX+1 consecutive samples. Outputs are levels only; any edge/pulse
//   generation happens downstream.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   rst       synchronous active-high reset
//   btn_in    [N-1:0] raw, asynchronous, bouncing button pins
//   btn_out   [N-1:0] debounced level per channel (registered)
//   settling  [N-1:0] high while a channel is qualifying a change (registered)

// Single debounce channel: synchroniser, settle counter and 4-state FSM.
module button_debouncer_ch #(
   parameter int CNT_MAX = 1_000_000,
   parameter int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_out,
   output logic settling
);

   typedef enum logic [1:0] {
      LOW      = 2'd0,
      RISE_CHK = 2'd1,
      HIGH     = 2'd2,
      FALL_CHK = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   state_t           state;
   logic             s1, s2;
   logic [CNT_W-1:0] cnt;

   // btn_out/settling are assigned together with each state transition so
   // they always decode the state being entered, with no extra cycle of lag.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         state    <= LOW;
         cnt      <= '0;
         btn_out  <= 1'b0;
         settling <= 1'b0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
         case (state)
            LOW: begin
               if (s2) begin
                  state    <= RISE_CHK;
                  cnt      <= '0;
                  settling <= 1'b1;
               end
            end
            RISE_CHK: begin
               if (!s2) begin
                  // bounce back low: abort, partial count is dropped
                  state    <= LOW;
                  cnt      <= '0;
                  settling <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state    <= HIGH;
                  cnt      <= '0;
                  btn_out  <= 1'b1;
                  settling <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HIGH: begin
               if (!s2) begin
                  state    <= FALL_CHK;
                  cnt      <= '0;
                  settling <= 1'b1;
               end
            end
            FALL_CHK: begin
               if (s2) begin
                  state    <= HIGH;
                  cnt      <= '0;
                  settling <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  state    <= LOW;
                  cnt      <= '0;
                  btn_out  <= 1'b0;
                  settling <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state    <= LOW;
               cnt      <= '0;
               btn_out  <= 1'b0;
               settling <= 1'b0;
            end
         endcase
      end
   end

endmodule

module button_debouncer #(
   parameter int N       = 5,
   parameter int CNT_MAX = 1_000_000,
   parameter int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] btn_in,
   output logic [N-1:0] btn_out,
   output logic [N-1:0] settling
);

   // Channels are fully independent; no shared counter or arbitration.
   for (genvar g = 0; g < N; g++) begin : g_ch
      button_debouncer_ch #(
         .CNT_MAX (CNT_MAX),
         .CNT_W   (CNT_W)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .btn_raw  (btn_in[g]),
         .btn_out  (btn_out[g]),
         .settling (settling[g])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

   localparam int N       = 5;
   localparam int CNT_MAX = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] btn_in = '0;
   logic [N-1:0] btn_out;
   logic [N-1:0] settling;

   always #5 clk = ~clk;

   button_debouncer #(.N(N), .CNT_MAX(CNT_MAX)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_out  (btn_out),
      .settling (settling)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Scoreboard: expected {btn_out, settling} after each edge.
   logic [2*N-1:0] sb_q[$];

   // Reference model: a level d (the pin value two samples ago) is accepted
   // once it has been seen on CNT_MAX+1 consecutive edges while differing
   // from the current output; while it differs but is not yet accepted the
   // channel reports settling.
   logic [N-1:0] m1 = '0, m2 = '0, m_out = '0, m_set = '0, m_prev = '0;
   int           m_run[N];

   // One clock: update model at the rising edge (inputs are stable there),
   // compare the DUT against the oldest expectation at the falling edge.
   task automatic tick();
      logic [N-1:0]   d;
      logic [2*N-1:0] exp_v;
      @(posedge clk);
      if (rst) begin
         m1 = '0; m2 = '0; m_out = '0; m_set = '0; m_prev = '0;
         for (int j = 0; j < N; j++) m_run[j] = 0;
      end else begin
         d  = m2;
         m2 = m1;
         m1 = btn_in;
         for (int j = 0; j < N; j++) begin
            if (d[j] == m_prev[j]) begin
               if (m_run[j] < 100) m_run[j]++;
            end else begin
               m_run[j] = 1;
            end
            if (d[j] == m_out[j]) m_set[j] = 1'b0;
            else if (m_run[j] >= CNT_MAX + 1) begin
               m_out[j] = d[j];
               m_set[j] = 1'b0;
            end else m_set[j] = 1'b1;
         end
         m_prev = d;
      end
      sb_q.push_back({m_out, m_set});
      @(negedge clk);
      exp_v = sb_q.pop_front();
      vectors++;
      if ({btn_out, settling} !== exp_v) begin
         miscompares++;
         $display("FAIL scoreboard t=%0t btn_out=%b settling=%b expected btn_out=%b settling=%b",
                  $time, btn_out, settling, exp_v[2*N-1:N], exp_v[N-1:0]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn_in = '1;
      repeat (2) tick();
      vectors++;
      if (btn_out !== '0 || settling !== '0) begin
         miscompares++;
         $display("FAIL reset_state btn_out=%b settling=%b expected 0/0", btn_out, settling);
      end
      btn_in = '0;
      rst = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_clean_press();
      btn_in[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         vectors++;
         if (btn_out[0] !== (i >= 6)) begin
            miscompares++;
            $display("FAIL clean_press_out edge k+%0d got %b expected %b", i, btn_out[0], (i >= 6));
         end
         vectors++;
         if (settling[0] !== (i >= 2 && i <= 5)) begin
            miscompares++;
            $display("FAIL clean_press_settling edge k+%0d got %b expected %b", i, settling[0], (i >= 2 && i <= 5));
         end
         vectors++;
         if (btn_out[4:1] !== 4'b0) begin
            miscompares++;
            $display("FAIL clean_press_others edge k+%0d got %b expected 0000", i, btn_out[4:1]);
         end
      end
      btn_in[0] = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_glitch();
      // 4-sample pulse: rejected
      btn_in[1] = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (i == 3) btn_in[1] = 1'b0;
         vectors++;
         if (btn_out[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch4_reject edge k+%0d got %b expected 0", i, btn_out[1]);
         end
      end
      // 5-sample pulse: accepted, rises at k+6
      btn_in[1] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i == 4) btn_in[1] = 1'b0;
         vectors++;
         if (btn_out[1] !== (i >= 6)) begin
            miscompares++;
            $display("FAIL glitch5_accept edge k+%0d got %b expected %b", i, btn_out[1], (i >= 6));
         end
      end
      repeat (10) tick();
   endtask

   task automatic test_bounce();
      logic pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      btn_in[2] = pat[0];
      for (int i = 0; i < 16; i++) begin
         tick();
         vectors++;
         if (btn_out[2] !== (i >= 11)) begin
            miscompares++;
            $display("FAIL bounce_rise edge k+%0d got %b expected %b", i, btn_out[2], (i >= 11));
         end
         btn_in[2] = (i + 1 < 6) ? pat[i+1] : 1'b1;
      end
      btn_in[2] = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_release_bounce();
      btn_in[3] = 1'b1;
      repeat (8) tick();
      vectors++;
      if (btn_out[3] !== 1'b1) begin
         miscompares++;
         $display("FAIL release_setup got %b expected 1", btn_out[3]);
      end
      // samples: 0,1,1, then 0 held; last high ends at k+3, fall at k+9
      btn_in[3] = 1'b0;
      for (int i = 0; i < 13; i++) begin
         tick();
         vectors++;
         if (btn_out[3] !== (i < 9)) begin
            miscompares++;
            $display("FAIL release_fall edge k+%0d got %b expected %b", i, btn_out[3], (i < 9));
         end
         btn_in[3] = (i == 0 || i == 1);
      end
      repeat (4) tick();
   endtask

   task automatic test_reset_mid_settle();
      btn_in[4] = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (i == 4) begin
            vectors++;
            if (settling[4] !== 1'b1) begin
               miscompares++;
               $display("FAIL reset_mid_pre_chk got %b expected 1", settling[4]);
            end
            rst = 1'b1;
         end
         if (i == 5) begin
            rst = 1'b0;
            vectors++;
            if (btn_out !== '0 || settling !== '0) begin
               miscompares++;
               $display("FAIL reset_mid_clear btn_out=%b settling=%b expected 0/0", btn_out, settling);
            end
         end
         if (i >= 5) begin
            vectors++;
            if (btn_out[4] !== (i >= 12)) begin
               miscompares++;
               $display("FAIL reset_mid_requal rst+%0d got %b expected %b", i - 5, btn_out[4], (i >= 12));
            end
         end
      end
      btn_in[4] = 1'b0;
      repeat (10) tick();
   endtask

   task automatic test_back_to_back();
      btn_in = '1;
      for (int i = 0; i < 26; i++) begin
         tick();
         if (i == 5) begin
            vectors++;
            if (btn_out !== '0) begin
               miscompares++;
               $display("FAIL parallel_pre got %b expected 00000", btn_out);
            end
         end
         if (i == 6) begin
            vectors++;
            if (btn_out !== '1) begin
               miscompares++;
               $display("FAIL parallel_rise got %b expected 11111", btn_out);
            end
         end
         if (i >= 7) begin
            for (int j = 0; j < N; j++) begin
               vectors++;
               if (btn_out[j] !== !(i >= 14 + 2*j)) begin
                  miscompares++;
                  $display("FAIL parallel_fall ch%0d edge k+%0d got %b expected %b",
                           j, i, btn_out[j], !(i >= 14 + 2*j));
               end
            end
         end
         for (int j = 0; j < N; j++)
            if (i == 7 + 2*j) btn_in[j] = 1'b0;
      end
      repeat (4) tick();
   endtask

   initial begin
      for (int j = 0; j < N; j++) m_run[j] = 0;
      test_reset();
      test_clean_press();
      test_glitch();
      test_bounce();
      test_release_bounce();
      test_reset_mid_settle();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
